// File: rtl/spi_master_mc_if.sv
// Bus-side request/status bundle for spi_master_mc.
// The register block drives it through 'master'; the SPI engine uses 'slave'.
interface spi_master_mc_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_SLAVES    = 4,
  parameter int DIV_WIDTH     = 16
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic                     enable;
  logic                     rd_we;
  logic [SEL_W-1:0]         slave_sel;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    data;
  logic [DIV_WIDTH-1:0]     divider;
  logic                     clock_phase;
  logic                     clock_polarity;
  logic                     busy;
  logic [DATA_WIDTH-1:0]    data_read;
  logic                     data_read_valid;
  logic                     sel_error;

  modport master (
    output enable, rd_we, slave_sel, address, data, divider, clock_phase, clock_polarity,
    input  busy, data_read, data_read_valid, sel_error
  );

  modport slave (
    input  enable, rd_we, slave_sel, address, data, divider, clock_phase, clock_polarity,
    output busy, data_read, data_read_valid, sel_error
  );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: frame = command bit, address, data; per-frame CPOL/CPHA/divider.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first port (address/data LSB-first).
module spi_master_mc #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_SLAVES    = 4,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  spi_master_mc_if.slave        bus,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic                  MISO,
  output logic                  SCK,
  output logic                  MOSI,
  output logic [NUM_SLAVES-1:0] SS
);

  localparam int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int FRAME_BITS = 1 + ADDRESS_WIDTH + DATA_WIDTH;
  localparam int HALF_W     = $clog2(2 * FRAME_BITS);
  localparam int IDX_W      = HALF_W - 1;

  localparam logic [HALF_W-1:0] LAST_HALF  = HALF_W'(2 * FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT   = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  FIRST_DATA = IDX_W'(1 + ADDRESS_WIDTH);
  localparam logic [SEL_W:0]    SLAVES_C   = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [NUM_SLAVES-1:0] ss_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SLAVES-1:0] ss;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      ss[i] = (sel != SEL_W'(i));
    end
    return ss;
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] rev_addr(input logic [ADDRESS_WIDTH-1:0] v);
    logic [ADDRESS_WIDTH-1:0] r;
    for (int i = 0; i < ADDRESS_WIDTH; i++) begin
      r[i] = v[ADDRESS_WIDTH-1-i];
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = v[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  // The whole frame goes out of the top bit; read frames carry zeros in the data field.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                     wr,
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]    dat,
    input logic                     lsb
  );
    logic [ADDRESS_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0]    d;
    a = lsb ? rev_addr(addr) : addr;
    d = wr ? (lsb ? rev_data(dat) : dat) : {DATA_WIDTH{1'b0}};
    return {wr, a, d};
  endfunction

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    cnt_q, div_q;
  logic [HALF_W-1:0]       half_q;
  logic [FRAME_BITS-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rx_q, data_read_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    rd_we_q, cpha_q, lsb_q;
  logic                    sck_q, sck_d;
  logic [NUM_SLAVES-1:0]   ss_q, ss_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    sel_err_q, sel_err_d;

  logic                    idle_s, sel_ok_s, accept_s, reject_s;
  logic                    tick_s, edge_s, lead_s, shift_s, sample_s, lsb_in_s;
  logic [IDX_W-1:0]        bit_idx_s;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in_s = lsb_first;
`else
  assign lsb_in_s = 1'b0;
`endif

  assign idle_s    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign sel_ok_s  = ({1'b0, bus.slave_sel} < SLAVES_C);
  assign accept_s  = idle_s && bus.enable && sel_ok_s;
  assign reject_s  = idle_s && bus.enable && !sel_ok_s;
  assign tick_s    = (cnt_q == {DIV_WIDTH{1'b0}});
  assign edge_s    = (state_q == ST_XFER) && tick_s;
  // Even XFER half-periods end on a leading edge because SCK starts each frame at CPOL.
  assign lead_s    = ~half_q[0];
  assign bit_idx_s = half_q[HALF_W-1:1];
  assign shift_s   = edge_s && (cpha_q ? (lead_s && (bit_idx_s != {IDX_W{1'b0}}))
                                       : (!lead_s && (bit_idx_s != LAST_BIT)));
  assign sample_s  = edge_s && (cpha_q ^ lead_s) && (bit_idx_s >= FIRST_DATA);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_s) state_d = ST_SETUP; else state_d = ST_IDLE;
      ST_SETUP: if (tick_s) state_d = ST_XFER; else state_d = ST_SETUP;
      ST_XFER:  if (edge_s && (half_q == LAST_HALF)) state_d = ST_HOLD; else state_d = ST_XFER;
      ST_HOLD:  if (tick_s) state_d = ST_DONE; else state_d = ST_HOLD;
      ST_DONE:  if (accept_s) state_d = ST_SETUP; else state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the pins are registered
  always_comb begin
    ss_d      = {NUM_SLAVES{1'b1}};
    busy_d    = 1'b0;
    valid_d   = 1'b0;
    sel_err_d = 1'b0;
    sck_d     = sck_q;
    case (state_d)
      ST_IDLE: begin
        sck_d     = bus.clock_polarity;
        sel_err_d = reject_s;
      end
      ST_SETUP: begin
        busy_d = 1'b1;
        if (accept_s) begin
          ss_d  = ss_decode(bus.slave_sel);
          sck_d = bus.clock_polarity;
        end else begin
          ss_d  = ss_decode(sel_q);
        end
      end
      ST_XFER, ST_HOLD: begin
        busy_d = 1'b1;
        ss_d   = ss_decode(sel_q);
        sck_d  = edge_s ? ~sck_q : sck_q;
      end
      ST_DONE: valid_d = ~rd_we_q;
      default: sck_d = sck_q;
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_q     <= bus.clock_polarity;
      ss_q      <= {NUM_SLAVES{1'b1}};
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      sck_q     <= sck_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Request latch, half-period timer and shift registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= {DIV_WIDTH{1'b0}};
      div_q       <= {DIV_WIDTH{1'b0}};
      half_q      <= {HALF_W{1'b0}};
      tx_q        <= {FRAME_BITS{1'b0}};
      rx_q        <= {DATA_WIDTH{1'b0}};
      data_read_q <= {DATA_WIDTH{1'b0}};
      sel_q       <= {SEL_W{1'b0}};
      rd_we_q     <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
    end else if (accept_s) begin
      cnt_q   <= bus.divider;
      div_q   <= bus.divider;
      half_q  <= {HALF_W{1'b0}};
      tx_q    <= build_frame(bus.rd_we, bus.address, bus.data, lsb_in_s);
      rx_q    <= {DATA_WIDTH{1'b0}};
      sel_q   <= bus.slave_sel;
      rd_we_q <= bus.rd_we;
      cpha_q  <= bus.clock_phase;
      lsb_q   <= lsb_in_s;
    end else begin
      case (state_q)
        ST_SETUP, ST_XFER, ST_HOLD: begin
          cnt_q <= tick_s ? div_q : (cnt_q - DIV_WIDTH'(1));
          if (edge_s) begin
            half_q <= half_q + HALF_W'(1);
          end
          if (shift_s) begin
            tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
          end
          if (sample_s) begin
            rx_q <= lsb_q ? {MISO, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], MISO};
          end
          if ((state_q == ST_HOLD) && tick_s) begin
            tx_q <= {FRAME_BITS{1'b0}};
            if (!rd_we_q) begin
              data_read_q <= rx_q;
            end
          end
        end
        ST_IDLE, ST_DONE: tx_q <= {FRAME_BITS{1'b0}};
        default: tx_q <= {FRAME_BITS{1'b0}};
      endcase
    end
  end

  assign SCK                 = sck_q;
  assign MOSI                = tx_q[FRAME_BITS-1];
  assign SS                  = ss_q;
  assign bus.busy            = busy_q;
  assign bus.data_read       = data_read_q;
  assign bus.data_read_valid = valid_q;
  assign bus.sel_error       = sel_err_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: a mode-aware SPI slave model plus hand-computed expectations.
module tb_spi_master_mc;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_master_mc_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_SLAVES(4), .DIV_WIDTH(16)) bus ();
  spi_master_mc_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .NUM_SLAVES(5), .DIV_WIDTH(4)) bus5 ();
  spi_master_mc_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .NUM_SLAVES(3), .DIV_WIDTH(4)) bus3 ();

  logic       MISO = 1'b0;
  logic       SCK, MOSI;
  logic [3:0] SS;
  logic       miso_x = 1'b0;
  logic       sck5, mosi5, sck3, mosi3;
  logic [4:0] ss5;
  logic [2:0] ss3;
`ifdef SPI_LSB_FIRST_EN
  logic       lsb_first = 1'b0;
  logic       lsb_zero  = 1'b0;
`endif

  spi_master_mc #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_SLAVES(4), .DIV_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .bus(bus),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .SS(SS));

  spi_master_mc #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .NUM_SLAVES(5), .DIV_WIDTH(4)) dut5 (
    .clock(clock), .reset(reset), .bus(bus5),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_zero),
`endif
    .MISO(miso_x), .SCK(sck5), .MOSI(mosi5), .SS(ss5));

  spi_master_mc #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .NUM_SLAVES(3), .DIV_WIDTH(4)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_zero),
`endif
    .MISO(miso_x), .SCK(sck3), .MOSI(mosi3), .SS(ss3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: samples MOSI and drives MISO on the edges implied by its CPOL/CPHA.
  logic        slv_cpol = 1'b0;
  logic        slv_cpha = 1'b0;
  logic [31:0] slv_tx   = 32'h0;
  logic [64:0] rx_vec   = 65'h0;
  int          rx_cnt   = 0;
  int          drv_idx  = 0;
  logic        ss_low;
  logic        ss_prev  = 1'b0;
  logic        sck_prev = 1'b0;
  assign ss_low = ~&SS;

  function automatic logic miso_bit(input int idx, input logic [31:0] tx);
    if (idx >= 33 && idx < 65) return tx[64-idx];
    else return 1'b0;
  endfunction

  always @(SCK or ss_low) begin
    if (ss_low && !ss_prev) begin
      rx_vec  = 65'h0;
      rx_cnt  = 0;
      drv_idx = 0;
      if (!slv_cpha) begin
        MISO    = miso_bit(0, slv_tx);
        drv_idx = 1;
      end
    end else if (ss_low && (SCK !== sck_prev)) begin
      if ((SCK !== slv_cpol) ^ slv_cpha) begin
        rx_vec = {rx_vec[63:0], MOSI};
        rx_cnt++;
      end else begin
        MISO = miso_bit(drv_idx, slv_tx);
        drv_idx++;
      end
    end
    ss_prev  = ss_low;
    sck_prev = SCK;
  end

  task automatic drive_req(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                           input logic [31:0] dat, input logic [15:0] div,
                           input logic cpha, input logic cpol);
    bus.rd_we          = wr;
    bus.slave_sel      = sel;
    bus.address        = addr;
    bus.data           = dat;
    bus.divider        = div;
    bus.clock_phase    = cpha;
    bus.clock_polarity = cpol;
    slv_cpha           = cpha;
    slv_cpol           = cpol;
  endtask

  task automatic pulse_start();
    bus.enable = 1'b1;
    @(negedge clock);
    bus.enable = 1'b0;
  endtask

  task automatic wait_frame(output int bc, output int vc);
    bc = 0;
    vc = 0;
    for (int i = 0; i < 5000 && bus.busy; i++) begin
      bc++;
      @(negedge clock);
    end
    check("frame_done", bus.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (bus.data_read_valid) vc++;
      @(negedge clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int bc, vc, r1, r2, gap;
    logic [3:0] ss_gap;
    reset = 1'b1;
    bus.enable = 1'b0;
    drive_req(1'b0, 2'd0, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0);
    bus5.enable = 1'b0; bus5.rd_we = 1'b1; bus5.slave_sel = 3'd0; bus5.address = 8'hA5;
    bus5.data = 8'h3C; bus5.divider = 4'd0; bus5.clock_phase = 1'b0; bus5.clock_polarity = 1'b0;
    bus3.enable = 1'b0; bus3.rd_we = 1'b1; bus3.slave_sel = 2'd0; bus3.address = 8'h5A;
    bus3.data = 8'hC3; bus3.divider = 4'd0; bus3.clock_phase = 1'b0; bus3.clock_polarity = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_ss", SS, 4'hF);
    check("rst_busy_sck_mosi", {bus.busy, SCK, MOSI}, 3'b000);
    check("rst_read", {bus.data_read, bus.data_read_valid, bus.sel_error}, 34'h0);
    check("rst_small_ss", {ss5, ss3}, 8'hFF);
    check("rst_small_pins", {sck5, mosi5, sck3, mosi3}, 4'b0000);
    reset = 1'b0;
    @(negedge clock);

    // Write, mode 0, divider 2, slave 1; inputs scrambled after the latch.
    drive_req(1'b1, 2'd1, 32'h10, 32'hA5A5A5A5, 16'd2, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    pulse_start();
    bus.address = 32'hFFFF_FFFF;
    bus.data    = 32'h0;
    bus.rd_we   = 1'b0;
    check("wr_start", {SS, bus.busy, MOSI}, {4'b1101, 1'b1, 1'b1});
    wait_frame(bc, vc);
    check("wr_busy_cycles", bc, 396);
    check("wr_no_valid", vc, 0);
    check("wr_bits", rx_cnt, 65);
    check("wr_frame", rx_vec, {1'b1, 32'h10, 32'hA5A5A5A5});
    check("wr_ss_idle", SS, 4'hF);
    check("wr_read_kept", bus.data_read, 32'h0);

    // Read, mode 3, divider 1, slave 2.
    drive_req(1'b0, 2'd2, 32'h55, 32'h1234_5678, 16'd1, 1'b1, 1'b1);
    slv_tx = 32'h3C5A_F00F;
    repeat (3) @(negedge clock);
    check("rd_idle_sck", SCK, 1'b1);
    pulse_start();
    check("rd_start_ss", SS, 4'b1011);
    wait_frame(bc, vc);
    check("rd_busy_cycles", bc, 264);
    check("rd_valid_pulses", vc, 1);
    check("rd_data", bus.data_read, 32'h3C5A_F00F);
    check("rd_mosi_frame", rx_vec, {1'b0, 32'h55, 32'h0});

    // Back-to-back writes with enable held high, divider 0.
    drive_req(1'b1, 2'd0, 32'hC3, 32'h0F0F_0001, 16'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    bus.enable = 1'b1;
    @(negedge clock);
    r1 = 0; r2 = 0; gap = 0; ss_gap = 4'h0;
    for (int i = 0; i < 1000 && bus.busy; i++) begin r1++; @(negedge clock); end
    for (int i = 0; i < 10 && !bus.busy; i++) begin gap++; ss_gap = SS; @(negedge clock); end
    bus.enable = 1'b0;
    for (int i = 0; i < 1000 && bus.busy; i++) begin r2++; @(negedge clock); end
    check("b2b_first_len", r1, 132);
    check("b2b_gap", gap, 1);
    check("b2b_gap_ss", ss_gap, 4'hF);
    check("b2b_second_len", r2, 132);
    check("b2b_second_frame", rx_vec, {1'b1, 32'hC3, 32'h0F0F_0001});
    check("b2b_read_held", bus.data_read, 32'h3C5A_F00F);

    // Reset held 3 cycles in the middle of a mode-2 frame.
    drive_req(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd3, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    pulse_start();
    check("mid_start_ss", SS, 4'b0111);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset", {SS, bus.busy, SCK, MOSI}, {4'hF, 1'b0, 1'b1, 1'b0});
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_after", {SS, bus.busy}, {4'hF, 1'b0});

    // Five slaves: index 4 is valid, 5 is rejected.
    bus5.slave_sel = 3'd4;
    bus5.enable = 1'b1;
    @(negedge clock);
    bus5.enable = 1'b0;
    check("ns5_accept", {ss5, bus5.busy}, {5'b01111, 1'b1});
    bc = 0;
    for (int i = 0; i < 200 && bus5.busy; i++) begin bc++; @(negedge clock); end
    check("ns5_busy_cycles", bc, 36);
    @(negedge clock);
    bus5.slave_sel = 3'd5;
    bus5.enable = 1'b1;
    @(negedge clock);
    bus5.enable = 1'b0;
    check("ns5_reject", {bus5.sel_error, bus5.busy, ss5}, {1'b1, 1'b0, 5'h1F});
    @(negedge clock);
    check("ns5_reject_pulse", {bus5.sel_error, bus5.busy}, 2'b00);

    // Three slaves: index 3 is rejected.
    bus3.slave_sel = 2'd3;
    bus3.enable = 1'b1;
    @(negedge clock);
    bus3.enable = 1'b0;
    check("ns3_reject", {bus3.sel_error, bus3.busy, ss3}, {1'b1, 1'b0, 3'h7});
    @(negedge clock);
    check("ns3_reject_pulse", {bus3.sel_error, bus3.busy, ss3}, {1'b0, 1'b0, 3'h7});

`ifdef SPI_LSB_FIRST_EN
    // LSB-first write of data 1: first data bit on the wire is 1.
    drive_req(1'b1, 2'd0, 32'h0, 32'h1, 16'd0, 1'b0, 1'b0);
    lsb_first = 1'b1;
    repeat (2) @(negedge clock);
    pulse_start();
    wait_frame(bc, vc);
    lsb_first = 1'b0;
    check("lsb_frame", rx_vec, {1'b1, 32'h0, 32'h8000_0000});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
